// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM state encoding and counter width.
package pc_sequencer_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_downcnt.sv
// Loadable down-counter with a zero flag; load wins over decrement, decrement stops at zero.
module pc_sequencer_downcnt
    import pc_sequencer_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, chooses sequential/stall/branch/restart each cycle,
// and drives the IF/ID flush and stall controls.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W      = 6,
    parameter int RESET_PC  = 0,
    parameter int FLUSH_CYC = 2,
    parameter int MAX_STALL = 7
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            hazard_in,
    input  logic            branch_taken_in,
    input  logic [PC_W-1:0] branch_target_in,
    input  logic            stall_in,
    input  logic            halt_in,
    output logic [PC_W-1:0] pc_out,
    output logic            flush_out,
    output logic            stall_out,
    output logic            valid_out,
    output logic            wdog_out,
    output logic [1:0]      state_out
);

    localparam logic [PC_W-1:0]  RST_PC     = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(MAX_STALL - 1);

    seq_state_t      state;
    logic [PC_W-1:0] pc_q;
    logic            flush_q, stall_q, valid_q, wdog_q;

    logic f_zero, f_load, f_dec;
    logic s_zero, s_load, s_dec;
    logic wd_fire, restart, run;

    // The stall counter runs from MAX_STALL-1 down; reaching zero while still stalled trips the watchdog.
    assign run     = (state == S_RUN);
    assign wd_fire = run && stall_in && s_zero;
    assign restart = hazard_in || wd_fire;

    assign f_load = (run && (restart || branch_taken_in)) || ((state == S_FLUSH) && hazard_in);
    assign f_dec  = (state == S_FLUSH) && !hazard_in;
    assign s_dec  = run && !restart && !branch_taken_in && !halt_in && stall_in;
    assign s_load = !s_dec;

    pc_sequencer_downcnt #(.RESET_VAL('0)) u_flush_cnt (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (f_load),
        .load_val (FLUSH_LOAD),
        .dec      (f_dec),
        .zero     (f_zero)
    );

    pc_sequencer_downcnt #(.RESET_VAL(STALL_LOAD)) u_stall_cnt (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (s_load),
        .load_val (STALL_LOAD),
        .dec      (s_dec),
        .zero     (s_zero)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= S_IDLE;
            pc_q    <= RST_PC;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            wdog_q  <= 1'b0;
        end else begin
            wdog_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_RUN;
                    valid_q <= 1'b1;
                end
                S_RUN: begin
                    if (restart) begin
                        pc_q    <= RST_PC;
                        flush_q <= 1'b1;
                        stall_q <= 1'b0;
                        valid_q <= 1'b0;
                        wdog_q  <= wd_fire;
                        state   <= S_FLUSH;
                    end else if (branch_taken_in) begin
                        pc_q    <= branch_target_in;
                        flush_q <= 1'b1;
                        stall_q <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= S_FLUSH;
                    end else if (halt_in) begin
                        valid_q <= 1'b0;
                        stall_q <= 1'b0;
                        state   <= S_HALT;
                    end else if (stall_in) begin
                        stall_q <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + PC_W'(1);
                        stall_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Wrong-path fetches: only a fresh hazard can change course here.
                    if (hazard_in) begin
                        pc_q    <= RST_PC;
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                        if (f_zero) begin
                            flush_q <= 1'b0;
                            valid_q <= 1'b1;
                            state   <= S_RUN;
                        end
                    end
                end
                default: begin
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out    = pc_q;
    assign flush_out = flush_q;
    assign stall_out = stall_q;
    assign valid_out = valid_q;
    assign wdog_out  = wdog_q;
    assign state_out = state;

endmodule
